alu_vec_runner: RTL and testbench

Parametrised on-chip vector runner for the ALU family. Successor to the fixed 32-bit, 16-entry pattern testbench: it stores test vectors, drives an external combinational ALU's operand and one-hot op-strobe inputs, and compares `out`/`zero`/`overflow` against expected values. It reports error count, first failing index and a pass flag, so ALU checks run self-checking in simulation or on an FPGA. The ALU instance sits beside this block; no ALU logic is inside it.

---
 rtl/alu_vec_runner_if.sv | 27 ++
 rtl/alu_vec_runner.sv | 169 ++++++++++++++++
 tb/tb_alu_vec_runner.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_vec_runner_if.sv
// ALU-side bus of alu_vec_runner: operands and one-hot op strobes out, result and flags back.
// master = vector runner, slave = the combinational ALU under test.
interface alu_vec_runner_if #(
  parameter int W = 32
);
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         op_add;
  logic         op_sub;
  logic         op_and;
  logic         op_or;
  logic         op_xor;
  logic         op_nor;
  logic [W-1:0] alu_out;
  logic         alu_zero;
  logic         alu_overflow;

  modport master (
    output alu_a, alu_b, op_add, op_sub, op_and, op_or, op_xor, op_nor,
    input  alu_out, alu_zero, alu_overflow
  );

  modport slave (
    input  alu_a, alu_b, op_add, op_sub, op_and, op_or, op_xor, op_nor,
    output alu_out, alu_zero, alu_overflow
  );
endinterface

// File: rtl/alu_vec_runner.sv
// On-chip vector runner: replays stored vectors into an external ALU and counts mismatches.
// Optional ALU_VEC_RUNNER_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
//   state | meaning
//   IDLE  | accepts vector writes and start
//   FETCH | reads vector idx into the operand/expect registers
//   APPLY | ALU driven, result compared and counted
//   DONE  | one-cycle done pulse, result stable
module alu_vec_runner #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                m_clock,
  input  logic                p_reset,
  input  logic                vec_we,
  input  logic [AW-1:0]       vec_addr,
  input  logic [3*W+8-1:0]    vec_wdata,
  input  logic                start,
  input  logic [AW:0]         n_vec,
  alu_vec_runner_if.master    alu,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [AW:0]         err_cnt,
  output logic [AW-1:0]       first_fail
);

  localparam int VW = 3*W + 8;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   N_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);
`ifdef ALU_VEC_RUNNER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, APPLY, DONE} state_t;

  state_t        state;
  logic [VW-1:0] mem [DEPTH];
  logic [VW-1:0] rd_word;
  logic [W-1:0]  rd_a;
  logic [W-1:0]  rd_b;
  logic [5:0]    rd_f;
  logic          rd_f_ok;
  logic [AW-1:0] idx;
  logic [AW:0]   n_reg;
  logic [AW:0]   n_sat;
  logic [5:0]    f_reg;
  logic [W-1:0]  exp_out_reg;
  logic          exp_zero_reg;
  logic          exp_ov_reg;
  logic          mismatch;
  logic          last_vec;
  logic          stop_run;

  assign rd_word = mem[idx];
  assign rd_a    = rd_word[VW-1 -: W];
  assign rd_b    = rd_word[VW-W-1 -: W];
  assign rd_f    = rd_word[W+7 -: 6];
  assign rd_f_ok = $onehot(rd_f);
  assign n_sat   = (n_vec > DEPTH_L) ? DEPTH_L : n_vec;

  always_comb begin
    mismatch = !$onehot(f_reg)
               || (alu.alu_out != exp_out_reg)
               || (alu.alu_zero != exp_zero_reg)
               || (alu.alu_overflow != exp_ov_reg);
    last_vec = ({1'b0, idx} == (n_reg - N_ONE));
    stop_run = last_vec || (STOP_ON_FAIL && mismatch);
  end

  // Memory is intentionally not reset; writes land only while the runner is idle.
  always_ff @(posedge m_clock) begin
    if (state == IDLE && vec_we && ({1'b0, vec_addr} < DEPTH_L))
      mem[vec_addr] <= vec_wdata;
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_cnt      <= '0;
      first_fail   <= '0;
      idx          <= '0;
      n_reg        <= '0;
      f_reg        <= '0;
      exp_out_reg  <= '0;
      exp_zero_reg <= 1'b0;
      exp_ov_reg   <= 1'b0;
      alu.alu_a    <= '0;
      alu.alu_b    <= '0;
      alu.op_add   <= 1'b0;
      alu.op_sub   <= 1'b0;
      alu.op_and   <= 1'b0;
      alu.op_or    <= 1'b0;
      alu.op_xor   <= 1'b0;
      alu.op_nor   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            err_cnt    <= '0;
            first_fail <= '0;
            idx        <= '0;
            n_reg      <= n_sat;
            if (n_sat == '0) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= FETCH;
              pass  <= 1'b0;
            end
          end
        end
        FETCH: begin
          f_reg        <= rd_f;
          exp_out_reg  <= rd_word[W+1:2];
          exp_zero_reg <= rd_word[1];
          exp_ov_reg   <= rd_word[0];
          alu.alu_a    <= rd_a;
          alu.alu_b    <= rd_b;
          alu.op_add   <= rd_f_ok & rd_f[5];
          alu.op_sub   <= rd_f_ok & rd_f[4];
          alu.op_and   <= rd_f_ok & rd_f[3];
          alu.op_or    <= rd_f_ok & rd_f[2];
          alu.op_xor   <= rd_f_ok & rd_f[1];
          alu.op_nor   <= rd_f_ok & rd_f[0];
          state        <= APPLY;
        end
        APPLY: begin
          alu.alu_a  <= '0;
          alu.alu_b  <= '0;
          alu.op_add <= 1'b0;
          alu.op_sub <= 1'b0;
          alu.op_and <= 1'b0;
          alu.op_or  <= 1'b0;
          alu.op_xor <= 1'b0;
          alu.op_nor <= 1'b0;
          if (mismatch) begin
            err_cnt <= err_cnt + N_ONE;
            if (err_cnt == '0)
              first_fail <= idx;
          end
          idx <= idx + IDX_ONE;
          if (stop_run) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (err_cnt == '0) && !mismatch;
          end else begin
            state <= FETCH;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_vec_runner.sv
// Directed bench for alu_vec_runner with a behavioural ALU beside it; run table plus
// hand sequences for reset mid-run and vector writes around start/busy.
module tb_alu_vec_runner;
  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int VW    = 3*W + 8;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b010000;
  localparam logic [5:0] F_AND = 6'b001000;
  localparam logic [5:0] F_OR  = 6'b000100;
  localparam logic [5:0] F_XOR = 6'b000010;
  localparam logic [5:0] F_NOR = 6'b000001;

`ifdef ALU_VEC_RUNNER_STOP_ON_FAIL_EN
  localparam int R4_LAT = 5;
  localparam int R4_STR = 2;
  localparam int SIM_LAT = 3;
  localparam int SIM_STR = 1;
`else
  localparam int R4_LAT = 9;
  localparam int R4_STR = 4;
  localparam int SIM_LAT = 5;
  localparam int SIM_STR = 2;
`endif

  logic m_clock = 1'b0;
  logic p_reset = 1'b0;
  always #5 m_clock = ~m_clock;

  logic          vec_we = 1'b0;
  logic [AW-1:0] vec_addr = '0;
  logic [VW-1:0] vec_wdata = '0;
  logic          start = 1'b0;
  logic [AW:0]   n_vec = '0;
  logic          busy, done, pass;
  logic [AW:0]   err_cnt;
  logic [AW-1:0] first_fail;

  alu_vec_runner_if #(.W(W)) alu_bus ();

  alu_vec_runner #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .vec_we     (vec_we),
    .vec_addr   (vec_addr),
    .vec_wdata  (vec_wdata),
    .start      (start),
    .n_vec      (n_vec),
    .alu        (alu_bus),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .first_fail (first_fail)
  );

  logic [W-1:0] r;
  logic         ov;
  logic [5:0]   strobes;
  assign strobes = {alu_bus.op_add, alu_bus.op_sub, alu_bus.op_and,
                    alu_bus.op_or, alu_bus.op_xor, alu_bus.op_nor};

  always_comb begin
    r  = '0;
    ov = 1'b0;
    if (alu_bus.op_add) begin
      r  = alu_bus.alu_a + alu_bus.alu_b;
      ov = (alu_bus.alu_a[W-1] == alu_bus.alu_b[W-1]) && (r[W-1] != alu_bus.alu_a[W-1]);
    end else if (alu_bus.op_sub) begin
      r  = alu_bus.alu_a - alu_bus.alu_b;
      ov = (alu_bus.alu_a[W-1] != alu_bus.alu_b[W-1]) && (r[W-1] != alu_bus.alu_a[W-1]);
    end else if (alu_bus.op_and) r = alu_bus.alu_a & alu_bus.alu_b;
    else if (alu_bus.op_or)  r = alu_bus.alu_a | alu_bus.alu_b;
    else if (alu_bus.op_xor) r = alu_bus.alu_a ^ alu_bus.alu_b;
    else if (alu_bus.op_nor) r = ~(alu_bus.alu_a | alu_bus.alu_b);
  end
  assign alu_bus.alu_out      = r;
  assign alu_bus.alu_zero     = (r == '0);
  assign alu_bus.alu_overflow = ov;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0][VW-1:0] w;
    int          nw;
    logic [AW:0] n;
    int          lat;
    int          err;
    int          ff;
    logic        pass;
    int          strobes;
    string       name;
  } run_t;

  function automatic logic [VW-1:0] mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [5:0] f, input logic [W-1:0] eo,
                                      input logic ez, input logic eov);
    return {a, b, f, eo, ez, eov};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_vec(input logic [AW-1:0] addr, input logic [VW-1:0] word);
    vec_we    = 1'b1;
    vec_addr  = addr;
    vec_wdata = word;
    @(posedge m_clock); #1;
    vec_we = 1'b0;
  endtask

  task automatic do_run(input logic [AW:0] n, input bit corrupt, output int lat,
                        output int nstr, output bit busy_ok, output bit multi,
                        output bit timeout);
    n_vec   = n;
    start   = 1'b1;
    lat     = 0;
    nstr    = 0;
    busy_ok = 1'b1;
    multi   = 1'b0;
    timeout = 1'b0;
    while (!timeout) begin
      @(posedge m_clock); #1;
      lat++;
      if (lat == 1) begin
        start     = 1'b0;
        vec_we    = corrupt;
        vec_addr  = 1;
        vec_wdata = mk(32'd0, 32'd0, 6'b000000, 32'd0, 1'b0, 1'b0);
      end else begin
        vec_we = 1'b0;
      end
      if ($countones(strobes) == 1) nstr++;
      if ($countones(strobes) > 1) multi = 1'b1;
      if (!busy) busy_ok = 1'b0;
      if (done) break;
      if (lat >= 200) timeout = 1'b1;
    end
    vec_we = 1'b0;
  endtask

  task automatic run_check(input run_t rr, input bit corrupt);
    int lat, nstr;
    bit busy_ok, multi, timeout;
    do_run(rr.n, corrupt, lat, nstr, busy_ok, multi, timeout);
    check({rr.name, "_timeout"}, 64'(timeout), 64'd0);
    check({rr.name, "_latency"}, 64'(lat), 64'(rr.lat));
    check({rr.name, "_err_cnt"}, 64'(err_cnt), 64'(rr.err));
    check({rr.name, "_first_fail"}, 64'(first_fail), 64'(rr.ff));
    check({rr.name, "_pass"}, 64'(pass), 64'(rr.pass));
    check({rr.name, "_strobes"}, 64'(nstr), 64'(rr.strobes));
    check({rr.name, "_busy_onehot"}, {62'd0, busy_ok, multi}, 64'b10);
    @(posedge m_clock); #1;
    check({rr.name, "_after_done"}, {62'd0, done, busy}, 64'd0);
    check({rr.name, "_pass_hold"}, 64'(pass), 64'(rr.pass));
  endtask

  run_t runs [5];
  logic [VW-1:0] nor0;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    run_t rr;
    bit   done_seen;
    nor0 = mk(32'd0, 32'd0, F_NOR, 32'hFFFF_FFFF, 1'b0, 1'b0);

    runs[0] = '{w: {4{nor0}}, nw: 0, n: 5'd31, lat: 33, err: 0, ff: 0, pass: 1'b1,
                strobes: 16, name: "sat16"};
    runs[1] = '{w: {nor0,
                    mk(32'hF0, 32'h0F, F_OR, 32'hFF, 1'b0, 1'b0),
                    mk(32'd7, 32'd7, F_SUB, 32'd0, 1'b1, 1'b0),
                    mk(32'd5, 32'd7, F_ADD, 32'd12, 1'b0, 1'b0)},
                nw: 3, n: 5'd3, lat: 7, err: 0, ff: 0, pass: 1'b1, strobes: 3, name: "basic3"};
    runs[2] = '{w: {nor0, nor0, nor0,
                    mk(32'h7FFF_FFFF, 32'd1, F_ADD, 32'h8000_0000, 1'b0, 1'b0)},
                nw: 1, n: 5'd1, lat: 3, err: 1, ff: 0, pass: 1'b0, strobes: 1, name: "ovf"};
    runs[3] = '{w: {mk(32'hFFFF_FFFF, 32'd0, F_NOR, 32'd0, 1'b1, 1'b0),
                    mk(32'd1, 32'd1, 6'b000011, 32'd0, 1'b1, 1'b0),
                    mk(32'hAAAA_5555, 32'hAAAA_5555, F_XOR, 32'd0, 1'b1, 1'b0),
                    mk(32'hFF00_FF00, 32'h0FF0_0FF0, F_AND, 32'h0F00_0F00, 1'b0, 1'b0)},
                nw: 4, n: 5'd4, lat: 9, err: 1, ff: 2, pass: 1'b0, strobes: 3, name: "badf"};
    runs[4] = '{w: {mk(32'd6, 32'd3, F_AND, 32'd2, 1'b0, 1'b0),
                    mk(32'd3, 32'd1, F_XOR, 32'd2, 1'b0, 1'b0),
                    mk(32'd10, 32'd3, F_SUB, 32'd8, 1'b0, 1'b0),
                    mk(32'd1, 32'd2, F_ADD, 32'd3, 1'b0, 1'b0)},
                nw: 4, n: 5'd4, lat: R4_LAT, err: 1, ff: 1, pass: 1'b0, strobes: R4_STR,
                name: "fail1"};

    repeat (2) @(posedge m_clock);
    #1;
    check("rst_ctrl", {61'd0, busy, done, pass}, 64'd0);
    check("rst_cnt", {55'd0, err_cnt, first_fail}, 64'd0);
    check("rst_ops", {alu_bus.alu_a, alu_bus.alu_b}, 64'd0);
    check("rst_strobes", 64'(strobes), 64'd0);
    @(negedge m_clock);
    p_reset = 1'b1;
    @(posedge m_clock); #1;

    for (int i = 0; i < DEPTH; i++) write_vec(AW'(i), nor0);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < runs[i].nw; j++) write_vec(AW'(j), runs[i].w[j]);
      run_check(runs[i], 1'b0);
    end

    rr = '{w: '0, nw: 0, n: 5'd0, lat: 1, err: 0, ff: 0, pass: 1'b1, strobes: 0, name: "nvec0"};
    run_check(rr, 1'b0);

    // Reset during APPLY(1) of the fail1 vectors, then rerun them.
    n_vec = 5'd4;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge m_clock); #1;
      if (k == 1) start = 1'b0;
    end
    check("apply1_strobe", 64'(strobes), 64'(F_SUB));
    p_reset = 1'b0;
    #1;
    check("midrst_busy", {62'd0, busy, done}, 64'd0);
    check("midrst_state", {49'd0, err_cnt, first_fail, strobes}, 64'd0);
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge m_clock); #1;
      if (done) done_seen = 1'b1;
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);
    @(negedge m_clock);
    p_reset = 1'b1;
    @(posedge m_clock); #1;
    rr = runs[4];
    rr.name = "rerun";
    run_check(rr, 1'b0);

    write_vec(0, mk(32'd1, 32'd1, F_ADD, 32'd2, 1'b0, 1'b0));
    write_vec(1, mk(32'd2, 32'd2, F_ADD, 32'd4, 1'b0, 1'b0));
    rr = '{w: '0, nw: 0, n: 5'd2, lat: 5, err: 0, ff: 0, pass: 1'b1, strobes: 2, name: "we_busy"};
    run_check(rr, 1'b1);
    rr.name = "readback";
    run_check(rr, 1'b0);

    vec_we    = 1'b1;
    vec_addr  = 0;
    vec_wdata = mk(32'd1, 32'd1, F_ADD, 32'd3, 1'b0, 1'b0);
    rr = '{w: '0, nw: 0, n: 5'd2, lat: SIM_LAT, err: 1, ff: 0, pass: 1'b0, strobes: SIM_STR,
           name: "we_start"};
    run_check(rr, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
